cbi980_mch_core: RTL and testbench
==================================

// Module: cbi980_mch_core
// PURPOSE
//  Register/FIFO core for the multichannel successor of the CBI980 audio controller.
//  Serves NCH audio channels (stereo or TDM slots). Each channel has its own RX and TX FIFO.
//  Bus side: CPU register port. Audio side: codec_if-style per-channel valid/ack stream.
//  Adds true full-depth FIFOs, level readback, overflow/underflow on both sides, W1C sticky flags and optional watermarks.
// PARAMETERS
//  NCH         2   channels, 1..4
//  SW          24  sample width; RX zero-extended to 32 on read, TX takes wr_data[SW-1:0]
//  DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2, 2..7; all entries usable
// PORTS
//  clk           in   1       core clock
//  ext_rst       in   1       reset, asynchronous, active-high
//  interrupt     out  1       level IRQ = |(enabled sticky|watermark flags)
//  core_rst      out  1       ext_rst | soft reset pulse; drives codec_if rst
//  init_done     in   1       codec init complete (readback only)
//  mclk_rate     out  3       LCFR[26:24] to codec
//  wr_addr       in   4       write register address
//  wr_data       in   32      write data
//  wr_en         in   1       write strobe
//  wr_err        out  1       comb: wr_en to non-writable/nonexistent address
//  rd_addr       in   4       read register address
//  rd_valid_in   in   1       read strobe
//  rd_data       out  32      read data, registered
//  rd_valid_out  out  1       rd_valid_in delayed 1 clk
//  aud_rx_vld    in   NCH     1-clk pulse: aud_rx_data valid for channel c
//  aud_rx_data   in   SW      shared RX sample bus
//  aud_tx_ack    in   NCH     1-clk pulse: codec consumed aud_tx_data[c]
//  aud_tx_data   out  NCH*SW  TX head sample per channel, comb from FIFO head
// BEHAVIOUR
//  Map: 0 CVR(ro 0xCB19_9810), 1 SR(ro), 2 CR, 3 LCFR, 4 IFR(W1C), 5 WMR, 6 LVLR(ro), 7 IER,
//   8+c DOUTc(wo), 12+c DINc(ro). Channels c>=NCH do not exist.
//  SR[8c+:8] = {2'b0, rx_wm, tx_wm, rxne, rxf, txnf, txe}; rxf = rx level==DEPTH.
//  CR: [3:0] txen, [7:4] rxen, [31] soft reset (self-clearing; one-clk core_rst; reads 0).
//  LCFR: [26:24] mclk_rate, [31] init_done (ro); rest 0.
//  IFR[4c+:4] = {rx_unf, tx_ovf, rx_ovf, tx_unf}. Write 1 clears; set beats clear in same clk.
//  LVLR[8c+:8] = {rx_level[3:0]... } no: LVLR[8c+:4]=tx_level, [8c+4+:4]=rx_level,
//   saturated to 15 if DEPTH_LOG2>3.
//  IER: [4c+:4] sticky enables, [16+2c+:2] {rx_wm, tx_wm} enables.
//  Reset (ext_rst async or core_rst sync): all regs/FIFO pointers/levels/flags 0,
//   rd_data=0, rd_valid_out=0, interrupt=0. Soft reset preserves LCFR, WMR, IER.
//  Read: on rd_valid_in, rd_data <= reg[rd_addr] next clk; holds otherwise.
//   DINc: pop if rx non-empty; if empty, data 0, set rx_unf, no pointer move.
//  Write DOUTc: push wr_data[SW-1:0] if tx not full; if full, drop and set tx_ovf.
//   Full is evaluated pre-cycle: simultaneous pop does not free space for that write.
//  RX push on aud_rx_vld[c]&rxen[c]: if full, drop sample and set rx_ovf; else push.
//   Simultaneous CPU pop and audio push: both happen, level unchanged.
//  TX pop on aud_tx_ack[c]&txen[c]: if empty, set tx_unf.
//   aud_tx_data[c] = 0 when empty or txen[c]=0 (mute, never stale data).
//  Disabled channel (rxen/txen=0): strobes ignored, no flags set, FIFO contents kept.
//  Pointers wrap mod DEPTH; level counter DEPTH_LOG2+1 bits, 0..DEPTH.
// CONFIGURATION
//  CBI980_WATERMARK_EN defined: WMR[15:8] rx_thr, WMR[7:0] tx_thr.
//   rx_wm = rx_thr!=0 & rx_level>=rx_thr; tx_wm = tx_level<=tx_thr.
//   Both flags are level (non-sticky).
//  Undefined: WMR reads 0, writes ignored (no wr_err); rx_wm=tx_wm=0; IER[23:16] reads 0.
// STRUCTURE
//  Package cbi980_pkg: register address localparams, CVR constant, IFR/SR bit-index constants.
//  Sub-module cbi980_fifo (SW, DEPTH_LOG2): sync FIFO with push/pop/level/full/empty/head.
//  Instantiated 2*NCH times via generate.
// TESTING
//  Write DOUT0 x16 (DEPTH 16), then a 17th -> 17th dropped, IFR[2]=1, LVLR tx0=15 sat/16 level.
//  Pulse aud_tx_ack[0] on empty TX0 with txen=1 -> aud_tx_data[0]=0, IFR[0]=1, interrupt iff IER[0].
//  17 aud_rx_vld[1] pulses, data 0x000001..0x000011 -> rx_ovf1; DIN1 reads 0x1..0x10 in order.
//  Read DIN0 empty -> rd_data=0 one clk after strobe, IFR[3]=1; write IFR=0x8 -> cleared.
//  Same-clk set and W1C of tx_unf -> stays 1.
//  Assert ext_rst mid-transfer -> all outputs 0 asynchronously.
//  Soft reset -> FIFOs empty, LCFR kept.
//  WATERMARK_EN: rx_thr=4; push 3 -> rx_wm=0; push 4th -> rx_wm=1, irq if IER[17].

Source files
------------

// File: rtl/cbi980_pkg.sv
// rtl/cbi980_pkg.sv - register map, identity and flag bit positions for the CBI980 multichannel core
package cbi980_pkg;

    localparam logic [3:0] A_CVR  = 4'd0;
    localparam logic [3:0] A_SR   = 4'd1;
    localparam logic [3:0] A_CR   = 4'd2;
    localparam logic [3:0] A_LCFR = 4'd3;
    localparam logic [3:0] A_IFR  = 4'd4;
    localparam logic [3:0] A_WMR  = 4'd5;
    localparam logic [3:0] A_LVLR = 4'd6;
    localparam logic [3:0] A_IER  = 4'd7;
    localparam logic [1:0] A_DOUT_HI = 2'b10;
    localparam logic [1:0] A_DIN_HI  = 2'b11;

    localparam logic [31:0] CVR_VALUE = 32'hCB19_9810;

    localparam int IFR_TX_UNF = 0;
    localparam int IFR_RX_OVF = 1;
    localparam int IFR_TX_OVF = 2;
    localparam int IFR_RX_UNF = 3;

    localparam int SR_TXE   = 0;
    localparam int SR_TXNF  = 1;
    localparam int SR_RXF   = 2;
    localparam int SR_RXNE  = 3;
    localparam int SR_TX_WM = 4;
    localparam int SR_RX_WM = 5;

    // LVLR has 4 bits per direction; deeper FIFOs report 15 once past it
    function automatic logic [3:0] sat_level(input logic [7:0] lvl);
        return (lvl > 8'd15) ? 4'hF : lvl[3:0];
    endfunction

endpackage

// File: rtl/cbi980_mch_core_if.sv
// rtl/cbi980_mch_core_if.sv - CPU register port of the CBI980 multichannel core
interface cbi980_mch_core_if;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_err;
    logic [3:0]  rd_addr;
    logic        rd_valid_in;
    logic [31:0] rd_data;
    logic        rd_valid_out;

    modport master (output wr_addr, wr_data, wr_en, rd_addr, rd_valid_in,
                    input  wr_err, rd_data, rd_valid_out);
    modport slave  (input  wr_addr, wr_data, wr_en, rd_addr, rd_valid_in,
                    output wr_err, rd_data, rd_valid_out);
endinterface

// File: rtl/cbi980_fifo.sv
// rtl/cbi980_fifo.sv - full-depth sync FIFO; push ignored when full, pop ignored when empty
module cbi980_fifo #(
    parameter int SW         = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [SW-1:0]         din,
    output logic [SW-1:0]         head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [SW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    // full/empty come from the registered level, so a same-clock pop never frees room for a push
    assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cbi980_mch_core.sv
// rtl/cbi980_mch_core.sv - CBI980 multichannel register/FIFO core; watermarks under CBI980_WATERMARK_EN
module cbi980_mch_core
    import cbi980_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int SW         = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                ext_rst,
    output logic                interrupt,
    output logic                core_rst,
    input  logic                init_done,
    output logic [2:0]          mclk_rate,
    cbi980_mch_core_if.slave    bus,
    input  logic [NCH-1:0]      aud_rx_vld,
    input  logic [SW-1:0]       aud_rx_data,
    input  logic [NCH-1:0]      aud_tx_ack,
    output logic [NCH*SW-1:0]   aud_tx_data
);
    localparam int LW = DEPTH_LOG2 + 1;

    logic              soft_pulse;
    logic [NCH-1:0]    txen, rxen;
    logic [4*NCH-1:0]  ifr, ier_stk, ifr_set, ifr_clr;
    logic [2*NCH-1:0]  ier_wm, wm_flag;
    logic [15:0]       wmr;
    logic [31:0]       rd_next;
    logic [NCH-1:0]    tx_push, tx_pop, rx_push, rx_pop;
    logic [NCH-1:0]    tx_full, tx_empty, rx_full, rx_empty;
    logic [SW-1:0]     tx_head [NCH];
    logic [SW-1:0]     rx_head [NCH];
    logic [LW-1:0]     tx_level [NCH];
    logic [LW-1:0]     rx_level [NCH];
    logic              wr_cr, wr_lcfr, wr_ifr, wr_ier, wr_dout, din_rd;
    logic              unused_wr_bits;

    assign wr_cr   = bus.wr_en & (bus.wr_addr == A_CR);
    assign wr_lcfr = bus.wr_en & (bus.wr_addr == A_LCFR);
    assign wr_ifr  = bus.wr_en & (bus.wr_addr == A_IFR);
    assign wr_ier  = bus.wr_en & (bus.wr_addr == A_IER);
    assign wr_dout = bus.wr_en & (bus.wr_addr[3:2] == A_DOUT_HI) & (int'(bus.wr_addr[1:0]) < NCH);
    assign din_rd  = bus.rd_valid_in & (bus.rd_addr[3:2] == A_DIN_HI);

    // WMR stays writable without watermarks so software never sees an error for it
    assign bus.wr_err = bus.wr_en & ~(wr_cr | wr_lcfr | wr_ifr | wr_ier | wr_dout |
                                      (bus.wr_addr == A_WMR));
    assign ifr_clr        = wr_ifr ? bus.wr_data[4*NCH-1:0] : '0;
    assign core_rst       = ext_rst | soft_pulse;
    assign interrupt      = ~core_rst & ((|(ifr & ier_stk)) | (|(wm_flag & ier_wm)));
    assign unused_wr_bits = ^bus.wr_data;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign tx_push[c] = wr_dout & (bus.wr_addr[1:0] == 2'(c));
        assign tx_pop[c]  = aud_tx_ack[c] & txen[c];
        assign rx_push[c] = aud_rx_vld[c] & rxen[c];
        assign rx_pop[c]  = din_rd & (bus.rd_addr[1:0] == 2'(c));

        assign ifr_set[4*c+IFR_TX_UNF] = tx_pop[c] & tx_empty[c];
        assign ifr_set[4*c+IFR_RX_OVF] = rx_push[c] & rx_full[c];
        assign ifr_set[4*c+IFR_TX_OVF] = tx_push[c] & tx_full[c];
        assign ifr_set[4*c+IFR_RX_UNF] = rx_pop[c] & rx_empty[c];

        cbi980_fifo #(.SW(SW), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
            .clk(clk), .rst(ext_rst), .clr(soft_pulse),
            .push(tx_push[c]), .pop(tx_pop[c]), .din(bus.wr_data[SW-1:0]),
            .head(tx_head[c]), .level(tx_level[c]), .full(tx_full[c]), .empty(tx_empty[c]));

        cbi980_fifo #(.SW(SW), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
            .clk(clk), .rst(ext_rst), .clr(soft_pulse),
            .push(rx_push[c]), .pop(rx_pop[c]), .din(aud_rx_data),
            .head(rx_head[c]), .level(rx_level[c]), .full(rx_full[c]), .empty(rx_empty[c]));

        // mute rather than replay a stale head when disabled or drained
        assign aud_tx_data[c*SW +: SW] = (txen[c] & ~tx_empty[c]) ? tx_head[c] : '0;

`ifdef CBI980_WATERMARK_EN
        assign wm_flag[2*c]   = (8'(tx_level[c]) <= wmr[7:0]);
        assign wm_flag[2*c+1] = (wmr[15:8] != 8'd0) && (8'(rx_level[c]) >= wmr[15:8]);
`else
        assign wm_flag[2*c +: 2] = 2'b00;
`endif
    end

`ifdef CBI980_WATERMARK_EN
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            wmr    <= '0;
            ier_wm <= '0;
        end else begin
            if (bus.wr_en && bus.wr_addr == A_WMR) wmr <= bus.wr_data[15:0];
            if (wr_ier) ier_wm <= bus.wr_data[16 +: 2*NCH];
        end
    end
`else
    assign wmr    = '0;
    assign ier_wm = '0;
`endif

    always_comb begin
        rd_next = '0;
        case (bus.rd_addr)
            A_CVR:  rd_next = CVR_VALUE;
            A_SR: begin
                for (int c = 0; c < NCH; c++) begin
                    rd_next[8*c+SR_TXE]   = tx_empty[c];
                    rd_next[8*c+SR_TXNF]  = ~tx_full[c];
                    rd_next[8*c+SR_RXF]   = rx_full[c];
                    rd_next[8*c+SR_RXNE]  = ~rx_empty[c];
                    rd_next[8*c+SR_TX_WM] = wm_flag[2*c];
                    rd_next[8*c+SR_RX_WM] = wm_flag[2*c+1];
                end
            end
            A_CR: begin
                rd_next[NCH-1:0] = txen;
                rd_next[4 +: NCH] = rxen;
            end
            A_LCFR: begin
                rd_next[31]    = init_done;
                rd_next[26:24] = mclk_rate;
            end
            A_IFR:  rd_next[4*NCH-1:0] = ifr;
            A_WMR:  rd_next[15:0] = wmr;
            A_LVLR: begin
                for (int c = 0; c < NCH; c++) begin
                    rd_next[8*c +: 4]   = sat_level(8'(tx_level[c]));
                    rd_next[8*c+4 +: 4] = sat_level(8'(rx_level[c]));
                end
            end
            A_IER: begin
                rd_next[4*NCH-1:0] = ier_stk;
                rd_next[16 +: 2*NCH] = ier_wm;
            end
            default: begin
                for (int c = 0; c < NCH; c++) begin
                    if (rx_pop[c] && !rx_empty[c]) rd_next[SW-1:0] = rx_head[c];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            soft_pulse       <= 1'b0;
            txen             <= '0;
            rxen             <= '0;
            ifr              <= '0;
            ier_stk          <= '0;
            mclk_rate        <= '0;
            bus.rd_data      <= '0;
            bus.rd_valid_out <= 1'b0;
        end else begin
            soft_pulse <= wr_cr & bus.wr_data[31];
            if (wr_lcfr) mclk_rate <= bus.wr_data[26:24];
            if (wr_ier)  ier_stk   <= bus.wr_data[4*NCH-1:0];
            if (soft_pulse) begin
                txen             <= '0;
                rxen             <= '0;
                ifr              <= '0;
                bus.rd_data      <= '0;
                bus.rd_valid_out <= 1'b0;
            end else begin
                if (wr_cr) begin
                    txen <= bus.wr_data[NCH-1:0];
                    rxen <= bus.wr_data[4 +: NCH];
                end
                // a new event in the same clock as its W1C wins
                ifr              <= (ifr & ~ifr_clr) | ifr_set;
                bus.rd_valid_out <= bus.rd_valid_in;
                if (bus.rd_valid_in) bus.rd_data <= rd_next;
            end
        end
    end
endmodule

// File: tb/tb_cbi980_mch_core.sv
// tb/tb_cbi980_mch_core.sv - directed self-checking bench for cbi980_mch_core
module tb_cbi980_mch_core;
    localparam int NCH = 2;
    localparam int SW  = 24;

    logic              clk = 1'b0;
    logic              ext_rst, interrupt, core_rst, init_done;
    logic [2:0]        mclk_rate;
    logic [NCH-1:0]    aud_rx_vld, aud_tx_ack;
    logic [SW-1:0]     aud_rx_data;
    logic [NCH*SW-1:0] aud_tx_data;
    logic [31:0]       rdv;
    int                total = 0;
    int                passed = 0;

    cbi980_mch_core_if bus();

    cbi980_mch_core #(.NCH(NCH), .SW(SW), .DEPTH_LOG2(4)) dut (
        .clk(clk), .ext_rst(ext_rst), .interrupt(interrupt), .core_rst(core_rst),
        .init_done(init_done), .mclk_rate(mclk_rate), .bus(bus),
        .aud_rx_vld(aud_rx_vld), .aud_rx_data(aud_rx_data),
        .aud_tx_ack(aud_tx_ack), .aud_tx_data(aud_tx_data));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd_addr = a; bus.rd_valid_in = 1'b1;
        @(negedge clk);
        bus.rd_valid_in = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic ack(input int c);
        @(negedge clk);
        aud_tx_ack[c] = 1'b1;
        @(negedge clk);
        aud_tx_ack = '0;
    endtask

    task automatic rx_pulse(input int c, input logic [SW-1:0] d);
        @(negedge clk);
        aud_rx_vld[c] = 1'b1; aud_rx_data = d;
        @(negedge clk);
        aud_rx_vld = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ext_rst = 1'b1; init_done = 1'b1;
        aud_rx_vld = '0; aud_tx_ack = '0; aud_rx_data = '0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
        bus.rd_addr = '0; bus.rd_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_rd_valid_out", {31'b0, bus.rd_valid_out}, 32'h0);
        chk("rst_interrupt", {31'b0, interrupt}, 32'h0);
        chk("rst_core_rst", {31'b0, core_rst}, 32'h1);
        ext_rst = 1'b0;
        @(negedge clk);
        chk("core_rst_released", {31'b0, core_rst}, 32'h0);

        rd(4'd0, rdv);
        chk("cvr", rdv, 32'hCB19_9810);
        chk("rd_valid_out_hi", {31'b0, bus.rd_valid_out}, 32'h1);
        @(negedge clk);
        chk("rd_data_hold", bus.rd_data, 32'hCB19_9810);
        chk("rd_valid_out_lo", {31'b0, bus.rd_valid_out}, 32'h0);

        bus.wr_data = 32'h0; bus.wr_en = 1'b1;
        bus.wr_addr = 4'd0;  #1 chk("wr_err_cvr", {31'b0, bus.wr_err}, 32'h1);
        bus.wr_addr = 4'd10; #1 chk("wr_err_dout2", {31'b0, bus.wr_err}, 32'h1);
        bus.wr_addr = 4'd5;  #1 chk("wr_err_wmr", {31'b0, bus.wr_err}, 32'h0);
        bus.wr_addr = 4'd2;  #1 chk("wr_err_cr", {31'b0, bus.wr_err}, 32'h0);
        @(negedge clk);
        bus.wr_en = 1'b0;

        wr(4'd3, 32'h0500_0000);
        chk("mclk_rate", {29'b0, mclk_rate}, 32'h5);
        rd(4'd3, rdv);
        chk("lcfr", rdv, 32'h8500_0000);

        for (int i = 0; i < 16; i++) wr(4'd8, 32'hAB00_0100 + i);
        chk("tx_muted_disabled", aud_tx_data[31:0], 32'h0);
        rd(4'd6, rdv);
        chk("lvlr_tx0_sat", rdv, 32'h0000_000F);
        rd(4'd1, rdv);
        chk("sr_tx0_full", rdv, 32'h0000_0300);
        wr(4'd8, 32'h0000_0999);
        rd(4'd4, rdv);
        chk("ifr_tx_ovf0", rdv, 32'h0000_0004);

        wr(4'd2, 32'h1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx0_head_%0d", i), {8'b0, aud_tx_data[23:0]}, 32'h100 + i);
            ack(0);
        end
        chk("tx0_empty_mute", {8'b0, aud_tx_data[23:0]}, 32'h0);
        chk("tx1_mute", {8'b0, aud_tx_data[47:24]}, 32'h0);

        wr(4'd7, 32'h1);
        chk("irq_masked_ovf", {31'b0, interrupt}, 32'h0);
        ack(0);
        chk("irq_tx_unf0", {31'b0, interrupt}, 32'h1);
        chk("tx0_unf_mute", {8'b0, aud_tx_data[23:0]}, 32'h0);
        rd(4'd4, rdv);
        chk("ifr_tx_unf0", rdv, 32'h0000_0005);
        wr(4'd4, 32'h5);
        rd(4'd4, rdv);
        chk("ifr_w1c", rdv, 32'h0);
        chk("irq_cleared", {31'b0, interrupt}, 32'h0);

        @(negedge clk);
        bus.wr_addr = 4'd4; bus.wr_data = 32'h1; bus.wr_en = 1'b1; aud_tx_ack[0] = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0; aud_tx_ack = '0;
        rd(4'd4, rdv);
        chk("ifr_set_beats_clr", rdv, 32'h1);
        wr(4'd4, 32'h1);

        wr(4'd2, 32'h21);
        for (int i = 1; i <= 17; i++) rx_pulse(1, SW'(i));
        rd(4'd4, rdv);
        chk("ifr_rx_ovf1", rdv, 32'h0000_0020);
        rd(4'd6, rdv);
        chk("lvlr_rx1_sat", rdv, 32'h0000_F000);
        rd(4'd1, rdv);
        chk("sr_rx1_full", rdv, 32'h0000_0F03);
        for (int i = 1; i <= 16; i++) begin
            rd(4'd13, rdv);
            chk($sformatf("din1_%0d", i), rdv, i);
        end
        rd(4'd13, rdv);
        chk("din1_empty", rdv, 32'h0);
        rd(4'd4, rdv);
        chk("ifr_rx_unf1", rdv, 32'h0000_00A0);

        rd(4'd12, rdv);
        chk("din0_empty", rdv, 32'h0);
        chk("din0_valid", {31'b0, bus.rd_valid_out}, 32'h1);
        rd(4'd4, rdv);
        chk("ifr_rx_unf0", rdv, 32'h0000_00A8);
        wr(4'd4, 32'h8);
        rd(4'd4, rdv);
        chk("ifr_rx_unf0_clr", rdv, 32'h0000_00A0);

        wr(4'd8, 32'h55);
        wr(4'd2, 32'h8000_0000);
        chk("soft_core_rst", {31'b0, core_rst}, 32'h1);
        rd(4'd6, rdv);
        chk("soft_lvlr", rdv, 32'h0);
        rd(4'd4, rdv);
        chk("soft_ifr", rdv, 32'h0);
        rd(4'd2, rdv);
        chk("soft_cr", rdv, 32'h0);
        rd(4'd3, rdv);
        chk("soft_lcfr_kept", rdv, 32'h8500_0000);
        rd(4'd7, rdv);
        chk("soft_ier_kept", rdv, 32'h1);

        wr(4'd2, 32'h3);
        wr(4'd8, 32'h0012_3456);
        chk("tx0_data", {8'b0, aud_tx_data[23:0]}, 32'h0012_3456);
        wr(4'd7, 32'h11);
        ack(1);
        chk("irq_tx_unf1", {31'b0, interrupt}, 32'h1);
        rd(4'd0, rdv);
        @(negedge clk);
        bus.rd_valid_in = 1'b1;
        @(posedge clk);
        #2 ext_rst = 1'b1;
        #1;
        chk("ext_rd_data", bus.rd_data, 32'h0);
        chk("ext_rd_valid_out", {31'b0, bus.rd_valid_out}, 32'h0);
        chk("ext_tx_data", aud_tx_data[31:0], 32'h0);
        chk("ext_mclk_rate", {29'b0, mclk_rate}, 32'h0);
        chk("ext_interrupt", {31'b0, interrupt}, 32'h0);
        bus.rd_valid_in = 1'b0;
        @(negedge clk);
        ext_rst = 1'b0;

`ifdef CBI980_WATERMARK_EN
        wr(4'd2, 32'h10);
        wr(4'd5, 32'h0400);
        wr(4'd7, 32'h0002_0000);
        for (int i = 0; i < 3; i++) rx_pulse(0, SW'(i));
        rd(4'd1, rdv);
        chk("rx_wm_3", {31'b0, rdv[5]}, 32'h0);
        chk("irq_wm_3", {31'b0, interrupt}, 32'h0);
        rx_pulse(0, SW'(3));
        rd(4'd1, rdv);
        chk("rx_wm_4", {31'b0, rdv[5]}, 32'h1);
        chk("irq_wm_4", {31'b0, interrupt}, 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
